car_game_sequencer: RTL and testbench
=====================================

# car_game_sequencer

Game-flow controller for the VGA car game. It sits beside `car_background` in the 25 MHz pixel-clock domain and sequences play through idle, countdown, run, pause, crash and game-over states. It derives a once-per-frame tick from the pixel counters, gates datapath motion, keeps lives, and keeps a 4-digit BCD score for the HEX displays.

## Interface
- `FRAME_LINE`, 480 — `v_count` value at which the frame tick fires (first blanking line).
- `DIGIT_FRAMES`, 60 — frames each countdown digit (3, 2, 1) is shown.
- `CRASH_FRAMES`, 120 — frames spent in CRASH.
- `SCORE_FRAMES`, 60 — frames per score increment.
- `LIVES`, 3 — lives at game start, range 1..3.
- `clk` in 1 — 25 MHz pixel clock, the same net that drives `VGA_CLK`.
- `rst` in 1 — reset; synchronous, active-high.
- `h_count` in 10, `v_count` in 10 — pixel counters from the VGA timing logic.
- `start` in 1 — play switch level (SW[9]).
- `speed_select` in 3 — requested speed (SW[3:1]).
- `collision` in 1 — collision flag from the datapath; may be a 1-cycle pulse.
- `pause` in 1 — pause button, active-high (already inverted from KEY).
- `state` out 3 — current state encoding.
- `run_en` out 1 — datapath may advance; 1 only in RUN.
- `frame_tick` out 1 — one-cycle pulse per frame.
- `speed` out 3 — latched speed.
- `score` out 16 — 4-digit BCD.
- `lives` out 2 — lives remaining.
- `countdown` out 2 — digit 3/2/1 in COUNTDOWN, else 0.
- `flash` out 1 — crash blink.
- `game_over` out 1 — 1 only in OVER.

## Operation
- States and encodings: IDLE=0, COUNTDOWN=1, RUN=2, PAUSE=3, CRASH=4, OVER=5.
- Priority, highest first: `rst`, then `start`=0 (any non-IDLE state goes to IDLE next cycle), then collision, then pause.
- IDLE
  - `score` holds its last value; `lives`=`LIVES`.
  - When `start`=1: clear `score` to 0, latch `speed`←`speed_select`, set digit=3 and the frame counter to 0, go to COUNTDOWN.
- COUNTDOWN
  - On each tick, increment the frame counter.
  - At `DIGIT_FRAMES`−1, clear the counter and decrement the digit.
  - When the digit goes from 1 to 0, go to RUN.
- RUN
  - `collision` is latched sticky on any cycle.
  - On a tick with the latch set: clear the latch, decrement `lives`, go to CRASH.
  - Otherwise, on a tick the score divider counts. At `SCORE_FRAMES`−1 it wraps and `score` += `speed`+1 (BCD), saturating at 9999.
  - A rising edge of `pause` (registered previous value) goes to PAUSE.
- PAUSE
  - Counters and score are frozen; `collision` is ignored.
  - A rising edge of `pause` returns to RUN. The score divider keeps its value.
- CRASH
  - `flash` toggles every 8 ticks, starting at 1 on entry.
  - After `CRASH_FRAMES` ticks: if `lives`=0, go to OVER; otherwise go to COUNTDOWN (digit 3, counter 0).
  - `flash`=0 on exit.
- OVER
  - `game_over`=1; `score` is held.
  - Leave only when `start`=0.
- Collision is ignored outside RUN, and the latch is cleared on leaving RUN.
- A pause edge in the same cycle as a tick with the collision latch set is discarded; CRASH wins.

## Timing
- `frame_tick` is registered. It is 1 for the cycle after `h_count`==0 && `v_count`==`FRAME_LINE`, so exactly once per 800×525-cycle frame.
- All outputs are registered. A state change taken on a `frame_tick` cycle is visible on the next cycle.
- `run_en` falls in the same cycle that `state` leaves RUN.
- Reset values:
  - `state`=IDLE; `run_en`, `frame_tick`, `flash`, `game_over` = 0.
  - `speed`=0, `score`=0, `lives`=`LIVES`, `countdown`=0.
  - All internal counters and latches are 0.
- Reset asserted mid-game behaves identically to reset at power-up; nothing is retained.
- `lives` never underflows: CRASH is only entered when `lives` ≥ 1.

## Structure
- `car_game_pkg` holds:
  - the state encodings;
  - `SCORE_W`=16 and `BCD_MAX`=16'h9999;
  - the `FLASH_PERIOD`=8 constant.
- Sub-module `bcd_score_adder`: combinational 4-digit BCD add of a 1..8 increment, with saturation at 9999.
- Everything else stays in one FSM module.

## Test plan
- Parameters for every scenario: `DIGIT_FRAMES`=2, `CRASH_FRAMES`=4, `SCORE_FRAMES`=3, free-running 800×525 counters.
- Reset, then `start`=1 → COUNTDOWN, with `countdown` showing 3,3,2,2,1,1 over 6 ticks, then RUN with `run_en`=1 one cycle after the 6th tick.
- RUN with `speed_select`=3, no collisions, 6 ticks → `score`=16'h0008.
- 1-cycle `collision` pulse mid-frame in RUN → at the next tick `state`=CRASH and `lives` 3→2. `flash` is 1 for the first 4 ticks, then `state`=COUNTDOWN.
- Three crashes → OVER with `game_over`=1 and `score` held. `start`=0 → IDLE next cycle; `lives`=3.
- Pause edge in RUN → PAUSE; 10 ticks plus a collision pulse leave `score` and `lives` unchanged. A second edge returns to RUN.
- `SCORE_FRAMES`=1, speed 7, 1250 ticks → `score`=16'h9999 and it stays there. `start`=0 mid-RUN → IDLE next cycle.

Source files
------------

// File: rtl/car_game_pkg.sv
// Shared types and constants for the car game flow controller.
package car_game_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_RUN       = 3'd2,
        S_PAUSE     = 3'd3,
        S_CRASH     = 3'd4,
        S_OVER      = 3'd5
    } state_t;

    localparam int unsigned SCORE_W      = 16;
    localparam logic [SCORE_W-1:0] BCD_MAX = 16'h9999;
    localparam int unsigned FLASH_PERIOD = 8;
    localparam int unsigned FLASH_W      = $clog2(FLASH_PERIOD);

endpackage

// File: rtl/bcd_score_adder.sv
// Combinational 4-digit BCD add of a small increment (1..8), saturating at 9999.
module bcd_score_adder
    import car_game_pkg::*;
(
    input  logic [SCORE_W-1:0] score,
    input  logic [3:0]         inc,
    output logic [SCORE_W-1:0] sum
);

    logic [SCORE_W-1:0] digits;
    logic [4:0]         d;
    logic               carry;

    // Ripple through the digits; a digit plus increment never exceeds 17, so one correction suffices.
    always_comb begin
        digits = '0;
        d      = '0;
        carry  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d = {1'b0, score[4*i +: 4]} + ((i == 0) ? {1'b0, inc} : {4'd0, carry});
            if (d > 5'd9) begin
                digits[4*i +: 4] = 4'(d - 5'd10);
                carry            = 1'b1;
            end else begin
                digits[4*i +: 4] = d[3:0];
                carry            = 1'b0;
            end
        end
        sum = carry ? BCD_MAX : digits;
    end

endmodule

// File: rtl/car_game_sequencer.sv
// Game-flow controller: idle/countdown/run/pause/crash/over sequencing, frame tick,
// lives and BCD score for the VGA car game.
module car_game_sequencer
    import car_game_pkg::*;
#(
    parameter int unsigned FRAME_LINE   = 480,
    parameter int unsigned DIGIT_FRAMES = 60,
    parameter int unsigned CRASH_FRAMES = 120,
    parameter int unsigned SCORE_FRAMES = 60,
    parameter int unsigned LIVES        = 3
)(
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  h_count,
    input  logic [9:0]  v_count,
    input  logic        start,
    input  logic [2:0]  speed_select,
    input  logic        collision,
    input  logic        pause,
    output logic [2:0]  state,
    output logic        run_en,
    output logic        frame_tick,
    output logic [2:0]  speed,
    output logic [15:0] score,
    output logic [1:0]  lives,
    output logic [1:0]  countdown,
    output logic        flash,
    output logic        game_over
);

    localparam int unsigned PHASE_MAX = (DIGIT_FRAMES > CRASH_FRAMES) ? DIGIT_FRAMES : CRASH_FRAMES;
    localparam int unsigned PHASE_W   = $clog2(PHASE_MAX + 1);
    localparam int unsigned DIV_W     = $clog2(SCORE_FRAMES + 1);

    state_t               st;
    logic [PHASE_W-1:0]   phase_cnt;
    logic [DIV_W-1:0]     score_div;
    logic [FLASH_W-1:0]   flash_cnt;
    logic                 coll_latch;
    logic                 pause_q;
    logic                 pause_edge;
    logic [3:0]           score_inc;
    logic [SCORE_W-1:0]   score_next;

    assign state      = st;
    assign pause_edge = pause & ~pause_q;
    assign score_inc  = 4'(speed) + 4'd1;

    bcd_score_adder u_adder (
        .score (score),
        .inc   (score_inc),
        .sum   (score_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= S_IDLE;
            run_en     <= 1'b0;
            frame_tick <= 1'b0;
            flash      <= 1'b0;
            game_over  <= 1'b0;
            speed      <= '0;
            score      <= '0;
            lives      <= 2'(LIVES);
            countdown  <= '0;
            phase_cnt  <= '0;
            score_div  <= '0;
            flash_cnt  <= '0;
            coll_latch <= 1'b0;
            pause_q    <= 1'b0;
        end else begin
            frame_tick <= (h_count == 10'd0) && (v_count == 10'(FRAME_LINE));
            pause_q    <= pause;

            // Dropping the play switch abandons the game from any state; score is kept for display.
            if (!start && st != S_IDLE) begin
                st         <= S_IDLE;
                run_en     <= 1'b0;
                flash      <= 1'b0;
                game_over  <= 1'b0;
                countdown  <= '0;
                lives      <= 2'(LIVES);
                phase_cnt  <= '0;
                flash_cnt  <= '0;
                coll_latch <= 1'b0;
            end else begin
                case (st)
                    S_IDLE: begin
                        lives <= 2'(LIVES);
                        if (start) begin
                            score     <= '0;
                            speed     <= speed_select;
                            countdown <= 2'd3;
                            phase_cnt <= '0;
                            score_div <= '0;
                            st        <= S_COUNTDOWN;
                        end
                    end

                    S_COUNTDOWN: begin
                        if (frame_tick) begin
                            if (phase_cnt == PHASE_W'(DIGIT_FRAMES - 1)) begin
                                phase_cnt <= '0;
                                if (countdown == 2'd1) begin
                                    countdown <= '0;
                                    st        <= S_RUN;
                                    run_en    <= 1'b1;
                                end else begin
                                    countdown <= countdown - 2'd1;
                                end
                            end else begin
                                phase_cnt <= phase_cnt + PHASE_W'(1);
                            end
                        end
                    end

                    S_RUN: begin
                        if (collision) coll_latch <= 1'b1;
                        // A pending crash on a tick outranks both scoring and a pause edge.
                        if (frame_tick && coll_latch) begin
                            coll_latch <= 1'b0;
                            lives      <= lives - 2'd1;
                            st         <= S_CRASH;
                            run_en     <= 1'b0;
                            flash      <= 1'b1;
                            phase_cnt  <= '0;
                            flash_cnt  <= '0;
                        end else begin
                            if (frame_tick) begin
                                if (score_div == DIV_W'(SCORE_FRAMES - 1)) begin
                                    score_div <= '0;
                                    score     <= score_next;
                                end else begin
                                    score_div <= score_div + DIV_W'(1);
                                end
                            end
                            if (pause_edge) begin
                                st         <= S_PAUSE;
                                run_en     <= 1'b0;
                                coll_latch <= 1'b0;
                            end
                        end
                    end

                    S_PAUSE: begin
                        if (pause_edge) begin
                            st     <= S_RUN;
                            run_en <= 1'b1;
                        end
                    end

                    S_CRASH: begin
                        if (frame_tick) begin
                            if (phase_cnt == PHASE_W'(CRASH_FRAMES - 1)) begin
                                phase_cnt <= '0;
                                flash     <= 1'b0;
                                flash_cnt <= '0;
                                if (lives == 2'd0) begin
                                    st        <= S_OVER;
                                    game_over <= 1'b1;
                                end else begin
                                    st        <= S_COUNTDOWN;
                                    countdown <= 2'd3;
                                end
                            end else begin
                                phase_cnt <= phase_cnt + PHASE_W'(1);
                                if (flash_cnt == FLASH_W'(FLASH_PERIOD - 1)) begin
                                    flash_cnt <= '0;
                                    flash     <= ~flash;
                                end else begin
                                    flash_cnt <= flash_cnt + FLASH_W'(1);
                                end
                            end
                        end
                    end

                    S_OVER: begin
                        game_over <= 1'b1;
                    end

                    default: begin
                        st     <= S_IDLE;
                        run_en <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_car_game_sequencer.sv
// Scoreboard bench: stimulus queues the expected output tuple for each DUT output change,
// a monitor pops and compares whenever the observed tuple changes.
`timescale 1ns/1ps
module tb_car_game_sequencer;

    localparam int FRAME_LEN = 16;

    logic        clk;
    logic        rst;
    logic [9:0]  h_count, v_count;

    logic        start_a, collision_a, pause_a;
    logic [2:0]  speed_sel_a;
    logic [2:0]  state_a, speed_a;
    logic        run_en_a, frame_tick_a, flash_a, game_over_a;
    logic [15:0] score_a;
    logic [1:0]  lives_a, countdown_a;

    logic        start_b, collision_b, pause_b;
    logic [2:0]  speed_sel_b;
    logic [2:0]  state_b, speed_b;
    logic        run_en_b, frame_tick_b, flash_b, game_over_b;
    logic [15:0] score_b;
    logic [1:0]  lives_b, countdown_b;

    car_game_sequencer #(.DIGIT_FRAMES(2), .CRASH_FRAMES(4), .SCORE_FRAMES(3), .LIVES(3)) dut_a (
        .clk(clk), .rst(rst), .h_count(h_count), .v_count(v_count),
        .start(start_a), .speed_select(speed_sel_a), .collision(collision_a), .pause(pause_a),
        .state(state_a), .run_en(run_en_a), .frame_tick(frame_tick_a), .speed(speed_a),
        .score(score_a), .lives(lives_a), .countdown(countdown_a), .flash(flash_a),
        .game_over(game_over_a)
    );

    car_game_sequencer #(.DIGIT_FRAMES(2), .CRASH_FRAMES(4), .SCORE_FRAMES(1), .LIVES(3)) dut_b (
        .clk(clk), .rst(rst), .h_count(h_count), .v_count(v_count),
        .start(start_b), .speed_select(speed_sel_b), .collision(collision_b), .pause(pause_b),
        .state(state_b), .run_en(run_en_b), .frame_tick(frame_tick_b), .speed(speed_b),
        .score(score_b), .lives(lives_b), .countdown(countdown_b), .flash(flash_b),
        .game_over(game_over_b)
    );

    logic [28:0] qa[$];
    logic [28:0] qb[$];
    logic [28:0] prev_a, prev_b, cur_a, cur_b, exp_v;
    bit          mon_on;
    bit          first;
    int          n_chk, n_fail, ev_a, ev_b;

    function automatic logic [28:0] mk(int st, int cd, int lv, logic [15:0] sc, int sp, int fl, int go, int re);
        return {3'(st), 2'(cd), 2'(lv), sc, 3'(sp), 1'(fl), 1'(go), 1'(re)};
    endfunction

    function automatic string fmt(logic [28:0] v);
        return $sformatf("st=%0d cd=%0d lv=%0d sc=%h sp=%0d fl=%0d go=%0d re=%0d",
                         v[28:26], v[25:24], v[23:22], v[21:6], v[5:3], v[2], v[1], v[0]);
    endfunction

    function automatic logic [15:0] to_bcd(int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compressed frame: the tick condition (h=0, v=480) recurs every FRAME_LEN cycles.
    initial begin
        int pos;
        pos     = 1;
        h_count = 10'd1;
        v_count = 10'd100;
        forever begin
            @(negedge clk);
            pos     = (pos + 1) % FRAME_LEN;
            h_count = (pos == 0) ? 10'd0 : 10'(pos);
            v_count = (pos == 0) ? 10'd480 : 10'd100;
        end
    end

    // Monitor: every change of the observable tuple consumes one expected entry.
    initial begin
        mon_on = 1'b0;
        first  = 1'b1;
        n_chk  = 0;
        n_fail = 0;
        ev_a   = 0;
        ev_b   = 0;
        forever begin
            @(negedge clk);
            cur_a = {state_a, countdown_a, lives_a, score_a, speed_a, flash_a, game_over_a, run_en_a};
            cur_b = {state_b, countdown_b, lives_b, score_b, speed_b, flash_b, game_over_b, run_en_b};
            if (mon_on) begin
                if (first || cur_a !== prev_a) begin
                    n_chk++;
                    if (qa.size() == 0) begin
                        n_fail++;
                        $display("FAIL dut_a event %0d: got %s, required no change", ev_a, fmt(cur_a));
                    end else begin
                        exp_v = qa.pop_front();
                        if (cur_a !== exp_v) begin
                            n_fail++;
                            $display("FAIL dut_a event %0d: got %s, required %s", ev_a, fmt(cur_a), fmt(exp_v));
                        end
                    end
                    ev_a++;
                end
                if (first || cur_b !== prev_b) begin
                    n_chk++;
                    if (qb.size() == 0) begin
                        n_fail++;
                        $display("FAIL dut_b event %0d: got %s, required no change", ev_b, fmt(cur_b));
                    end else begin
                        exp_v = qb.pop_front();
                        if (cur_b !== exp_v) begin
                            n_fail++;
                            $display("FAIL dut_b event %0d: got %s, required %s", ev_b, fmt(cur_b), fmt(exp_v));
                        end
                    end
                    ev_b++;
                end
                first = 1'b0;
            end
            prev_a = cur_a;
            prev_b = cur_b;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns at the negedge inside the n-th following frame_tick cycle.
    task automatic wait_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            int guard;
            guard = 0;
            do begin
                @(negedge clk);
                guard++;
            end while (frame_tick_a !== 1'b1 && guard < 4 * FRAME_LEN);
            if (frame_tick_a !== 1'b1) begin
                n_chk++;
                n_fail++;
                $display("FAIL frame_tick_timeout: got no tick in %0d cycles, required one", guard);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish by 1 ms, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        start_a = 1'b0; collision_a = 1'b0; pause_a = 1'b0; speed_sel_a = 3'd0;
        start_b = 1'b0; collision_b = 1'b0; pause_b = 1'b0; speed_sel_b = 3'd0;
        step(4);
        qa.push_back(mk(0, 0, 3, 16'h0000, 0, 0, 0, 0));
        qb.push_back(mk(0, 0, 3, 16'h0000, 0, 0, 0, 0));
        rst = 1'b0;
        mon_on = 1'b1;
        step(2);

        // Start: countdown 3,3,2,2,1,1 then RUN
        wait_ticks(1);
        qa.push_back(mk(1, 3, 3, 16'h0000, 3, 0, 0, 0));
        qa.push_back(mk(1, 2, 3, 16'h0000, 3, 0, 0, 0));
        qa.push_back(mk(1, 1, 3, 16'h0000, 3, 0, 0, 0));
        qa.push_back(mk(2, 0, 3, 16'h0000, 3, 0, 0, 1));
        speed_sel_a = 3'd3;
        start_a = 1'b1;
        wait_ticks(6);

        // Scoring at speed 3: +4 every third tick
        qa.push_back(mk(2, 0, 3, 16'h0004, 3, 0, 0, 1));
        qa.push_back(mk(2, 0, 3, 16'h0008, 3, 0, 0, 1));
        wait_ticks(6);

        // Crash 1 from a mid-frame collision pulse
        step(5);
        collision_a = 1'b1; step(1); collision_a = 1'b0;
        qa.push_back(mk(4, 0, 2, 16'h0008, 3, 1, 0, 0));
        wait_ticks(1);
        qa.push_back(mk(1, 3, 2, 16'h0008, 3, 0, 0, 0));
        wait_ticks(4);
        qa.push_back(mk(1, 2, 2, 16'h0008, 3, 0, 0, 0));
        qa.push_back(mk(1, 1, 2, 16'h0008, 3, 0, 0, 0));
        qa.push_back(mk(2, 0, 2, 16'h0008, 3, 0, 0, 1));
        wait_ticks(6);

        // Crash 2
        step(3);
        collision_a = 1'b1; step(1); collision_a = 1'b0;
        qa.push_back(mk(4, 0, 1, 16'h0008, 3, 1, 0, 0));
        wait_ticks(1);
        qa.push_back(mk(1, 3, 1, 16'h0008, 3, 0, 0, 0));
        wait_ticks(4);
        qa.push_back(mk(1, 2, 1, 16'h0008, 3, 0, 0, 0));
        qa.push_back(mk(1, 1, 1, 16'h0008, 3, 0, 0, 0));
        qa.push_back(mk(2, 0, 1, 16'h0008, 3, 0, 0, 1));
        wait_ticks(6);

        // Crash 3 with the last life: OVER, held until start drops
        step(3);
        collision_a = 1'b1; step(1); collision_a = 1'b0;
        qa.push_back(mk(4, 0, 0, 16'h0008, 3, 1, 0, 0));
        wait_ticks(1);
        qa.push_back(mk(5, 0, 0, 16'h0008, 3, 0, 1, 0));
        wait_ticks(4);
        wait_ticks(2);
        qa.push_back(mk(0, 0, 3, 16'h0008, 3, 0, 0, 0));
        start_a = 1'b0;
        step(2);

        // Pause: frozen for 10 ticks, collision ignored, divider resumes where it stopped
        wait_ticks(1);
        qa.push_back(mk(1, 3, 3, 16'h0000, 1, 0, 0, 0));
        qa.push_back(mk(1, 2, 3, 16'h0000, 1, 0, 0, 0));
        qa.push_back(mk(1, 1, 3, 16'h0000, 1, 0, 0, 0));
        qa.push_back(mk(2, 0, 3, 16'h0000, 1, 0, 0, 1));
        speed_sel_a = 3'd1;
        start_a = 1'b1;
        wait_ticks(6);
        qa.push_back(mk(2, 0, 3, 16'h0002, 1, 0, 0, 1));
        wait_ticks(4);
        step(3);
        qa.push_back(mk(3, 0, 3, 16'h0002, 1, 0, 0, 0));
        pause_a = 1'b1; step(2); pause_a = 1'b0;
        step(4);
        collision_a = 1'b1; step(1); collision_a = 1'b0;
        wait_ticks(10);
        step(3);
        qa.push_back(mk(2, 0, 3, 16'h0002, 1, 0, 0, 1));
        pause_a = 1'b1; step(1); pause_a = 1'b0;
        qa.push_back(mk(2, 0, 3, 16'h0004, 1, 0, 0, 1));
        wait_ticks(2);
        step(1);
        qa.push_back(mk(0, 0, 3, 16'h0004, 1, 0, 0, 0));
        start_a = 1'b0;
        step(2);

        // Fast-scoring instance: +8 per tick up to saturation at 9999
        wait_ticks(1);
        qb.push_back(mk(1, 3, 3, 16'h0000, 7, 0, 0, 0));
        qb.push_back(mk(1, 2, 3, 16'h0000, 7, 0, 0, 0));
        qb.push_back(mk(1, 1, 3, 16'h0000, 7, 0, 0, 0));
        qb.push_back(mk(2, 0, 3, 16'h0000, 7, 0, 0, 1));
        speed_sel_b = 3'd7;
        start_b = 1'b1;
        wait_ticks(6);
        for (int k = 1; k <= 1250; k++)
            qb.push_back(mk(2, 0, 3, to_bcd((8 * k > 9999) ? 9999 : 8 * k), 7, 0, 0, 1));
        wait_ticks(1255);
        step(1);
        qb.push_back(mk(0, 0, 3, 16'h9999, 7, 0, 0, 0));
        start_b = 1'b0;
        step(4);

        n_chk++;
        if (qa.size() != 0) begin
            n_fail++;
            $display("FAIL dut_a leftover: got %0d unmatched expectations, required 0", qa.size());
        end
        n_chk++;
        if (qb.size() != 0) begin
            n_fail++;
            $display("FAIL dut_b leftover: got %0d unmatched expectations, required 0", qb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
